// File: rtl/timetag_scheduler.sv
// rtl/timetag_scheduler.sv - merges latched period time tags into the event packet stream on packet boundaries
module timetag_scheduler #(
    parameter logic [3:0] TAG_HDR = 4'hF,
    parameter int         DW      = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          period_done,
    input  logic [47:0]   period,
    input  logic          ev_valid,
    input  logic [DW-1:0] ev_data,
    input  logic          ev_last,
    output logic          ev_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_is_tag,
    input  logic          out_ready,
    output logic          tag_pending,
    output logic [7:0]    tag_drops
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] tag_word;
    logic          load;
    logic          tag_load;
    logic          ev_fire;
    logic          strobe;
    logic          unused_period_hi;

    // Only the low 44 bits of the period count fit beside the header nibble.
    assign unused_period_hi = ^period[47:44];

    always_comb begin
        load     = !out_valid || out_ready;
        tag_load = load && (state == IDLE) && tag_pending;
        ev_ready = rst_n && load && ((state == PKT) || !tag_pending);
        ev_fire  = ev_valid && ev_ready;
        strobe   = period_done && en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tag_word    <= '0;
            tag_pending <= 1'b0;
            tag_drops   <= 8'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_is_tag  <= 1'b0;
        end else begin
            // A strobe landing while the old tag moves to the output is not a drop.
            if (strobe) begin
                tag_word    <= {TAG_HDR, period[DW-5:0]};
                tag_pending <= 1'b1;
                if (tag_pending && !tag_load && tag_drops != 8'hFF) begin
                    tag_drops <= tag_drops + 8'd1;
                end
            end else if (tag_load) begin
                tag_pending <= 1'b0;
            end

            if (tag_load) begin
                out_valid  <= 1'b1;
                out_data   <= tag_word;
                out_last   <= 1'b1;
                out_is_tag <= 1'b1;
            end else if (ev_fire) begin
                out_valid  <= 1'b1;
                out_data   <= ev_data;
                out_last   <= ev_last;
                out_is_tag <= 1'b0;
                state      <= ev_last ? IDLE : PKT;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
